eth_fcs_framer: RTL



---
 rtl/eth_pkg.sv | 21 ++
 rtl/crc.sv | 45 ++++
 rtl/eth_fcs_framer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state encoding and CRC-32/framing constants for the FX transmit path
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_SEED = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR  = 32'hFFFFFFFF;

  localparam logic [3:0] NIB_PREAMBLE = 4'h5;
  localparam logic [3:0] NIB_SFD      = 4'hD;

endpackage

// File: rtl/crc.sv
// rtl/crc.sv - parallel MSB-first CRC register; input word is bit-reversed so bit0 enters first (reflected input)
module crc #(
  parameter int                   DATA_WIDTH = 4,
  parameter int                   CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] POLY       = '0,
  parameter logic [CRC_WIDTH-1:0] SEED       = '1,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT    = '1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_CLR,
  input  logic                  IN_ENA,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic [CRC_WIDTH-1:0]  CRC_OUT
);

  logic [CRC_WIDTH-1:0]  crc_q;
  logic [CRC_WIDTH-1:0]  crc_next;
  logic [DATA_WIDTH-1:0] din_rev;

  always_comb begin
    din_rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      din_rev[i] = IN_DATA[DATA_WIDTH-1-i];
    end
    crc_next = crc_q;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      crc_next = {crc_next[CRC_WIDTH-2:0], 1'b0} ^
                 ({CRC_WIDTH{crc_next[CRC_WIDTH-1] ^ din_rev[i]}} & POLY);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      crc_q <= SEED;
    end else if (IN_CLR) begin
      crc_q <= SEED;
    end else if (IN_ENA) begin
      crc_q <= crc_next;
    end
  end

  assign CRC_OUT = crc_q ^ XOR_OUT;

endmodule

// File: rtl/eth_fcs_framer.sv
// rtl/eth_fcs_framer.sv - wraps a builder nibble stream with preamble/SFD, zero pad, CRC-32 FCS and inter-frame gap
module eth_fcs_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_NIBBLES      = 120,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [3:0] IN_DATA,
  input  logic       IN_LAST,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [3:0] OUT_DATA,
  output logic       OUT_LAST,
  output logic       BUSY,
  output logic       UNDERRUN
);

  localparam logic [15:0] PRE_N = 16'(PREAMBLE_NIBBLES);
  localparam logic [15:0] MIN_N = 16'(MIN_NIBBLES);
  localparam logic [15:0] IFG_N = 16'(IFG_NIBBLES);

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;
  logic [15:0] dcnt;
  logic        underrun_q;
  logic        hs;
  logic        crc_clr;
  logic        crc_ena;
  logic [3:0]  crc_din;
  logic [31:0] crc_out;
  logic [3:0]  fcs_nib;

  assign hs       = OUT_VALID & OUT_READY;
  assign BUSY     = (state != ST_IDLE);
  assign UNDERRUN = underrun_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (IN_VALID) next_state = ST_PREAMBLE;
      ST_PREAMBLE: if (hs && (cnt + 16'd1 >= PRE_N)) next_state = ST_SFD;
      ST_SFD:      if (hs) next_state = ST_DATA;
      ST_DATA:     if (hs && IN_LAST) next_state = (dcnt + 16'd1 < MIN_N) ? ST_PAD : ST_FCS;
      ST_PAD:      if (hs && (dcnt + 16'd1 >= MIN_N)) next_state = ST_FCS;
      ST_FCS:      if (hs && (cnt[2:0] == 3'd7)) next_state = ST_IFG;
      ST_IFG:      if (cnt + 16'd1 >= IFG_N) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // cnt serves preamble length, FCS nibble index and gap length; dcnt is data+pad length
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt        <= '0;
      dcnt       <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (next_state != state || state == ST_IDLE) begin
        cnt <= '0;
      end else if (state == ST_IFG || ((state == ST_PREAMBLE || state == ST_FCS) && hs)) begin
        cnt <= cnt + 16'd1;
      end
      if (state == ST_IDLE) begin
        dcnt <= '0;
      end else if ((state == ST_DATA || state == ST_PAD) && hs && (dcnt < MIN_N)) begin
        dcnt <= dcnt + 16'd1;
      end
      if (state == ST_IDLE && IN_VALID) begin
        underrun_q <= 1'b0;
      end else if (state == ST_DATA && !IN_VALID) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // FCS goes out MSB of the non-reflected register first, so each nibble is bit-reversed
  always_comb begin
    fcs_nib = crc_out[{~cnt[2:0], 2'b11} -: 4];
  end

  always_comb begin
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = 4'h0;
    OUT_LAST  = 1'b0;
    crc_clr   = 1'b0;
    crc_ena   = 1'b0;
    crc_din   = 4'h0;
    case (state)
      ST_IDLE: crc_clr = IN_VALID;
      ST_PREAMBLE: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = NIB_PREAMBLE;
      end
      ST_SFD: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = NIB_SFD;
      end
      ST_DATA: begin
        OUT_VALID = IN_VALID;
        OUT_DATA  = IN_DATA;
        IN_READY  = OUT_READY;
        crc_ena   = IN_VALID & OUT_READY;
        crc_din   = IN_DATA;
      end
      ST_PAD: begin
        OUT_VALID = 1'b1;
        crc_ena   = OUT_READY;
      end
      ST_FCS: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = {fcs_nib[0], fcs_nib[1], fcs_nib[2], fcs_nib[3]};
        OUT_LAST  = (cnt[2:0] == 3'd7);
      end
      default: ;
    endcase
  end

  crc #(
    .DATA_WIDTH (4),
    .CRC_WIDTH  (32),
    .POLY       (CRC32_POLY),
    .SEED       (CRC32_SEED),
    .XOR_OUT    (CRC32_XOR)
  ) u_crc (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .IN_CLR  (crc_clr),
    .IN_ENA  (crc_ena),
    .IN_DATA (crc_din),
    .CRC_OUT (crc_out)
  );

endmodule
